// File: rtl/kernel_bc_sched_pkg.sv
// kernel_bc_sched_pkg: shared state encoding, widths and join helper for the start scheduler
package kernel_bc_sched_pkg;
  typedef enum logic {IDLE = 1'b0, START = 1'b1} state_t;
  localparam int ITER_W = 32;
  localparam int PERF_W = 32;
  localparam int MAX_SRC = 8;
  // All-ones join over the low n bits of v; bits above n are forced high so they never block.
  function automatic logic join_all(input logic [MAX_SRC-1:0] v, input int n);
    return &(v | ~((MAX_SRC'(1) << n) - MAX_SRC'(1)));
  endfunction
endpackage

// File: rtl/kernel_bc_sched_credit_cnt.sv
// kernel_bc_sched_credit_cnt: up/down count of launched-but-not-done iterations with limit and range errors
module kernel_bc_sched_credit_cnt #(
  parameter int MAX = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         below_max,
  output logic         underflow,
  output logic         overflow
);
  localparam logic [W-1:0] MAX_C = W'(MAX);
  // Limit compare and out-of-range step detection; a simultaneous inc/dec is a no-op and never an error.
  always_comb begin
    below_max = count < MAX_C;
    underflow = dec && !inc && count == '0;
    overflow = inc && !dec && count == MAX_C;
  end
  // Net count of launches minus completions; out-of-range steps hold the current value.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc && !dec && !overflow) count <= count + 1'b1;
    else if (dec && !inc && !underflow) count <= count - 1'b1;
endmodule

// File: rtl/kernel_bc_start_scheduler.sv
// kernel_bc_start_scheduler: joins NUM_SRC start FIFOs and launches the consumer via ap_start/ap_ready.
// Optional stall counter output enabled by defining KERNEL_BC_START_SCHED_PERF_EN.
module kernel_bc_start_scheduler
  import kernel_bc_sched_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [NUM_SRC-1:0]   src_empty_n,
  output logic [NUM_SRC-1:0]   src_read,
  output logic                 ap_start,
  input  logic                 ap_ready,
  input  logic                 ap_done,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic [ITER_W-1:0]    iter_count,
  output logic                 busy,
  output logic                 err
`ifdef KERNEL_BC_START_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0]    stall_cycles
`endif
);
  state_t state;
  logic joined, launch, below_max, underflow, overflow;
  // Join detect, Moore start output and the pop strobe that coincides with the accepted start.
  always_comb begin
    joined = join_all(MAX_SRC'(src_empty_n), NUM_SRC);
    ap_start = state == START;
    launch = ap_start && ap_ready;
    src_read = {NUM_SRC{launch}};
    busy = ap_start || outstanding != '0;
  end
  // Two-state launch FSM; once START is entered it waits for ap_ready regardless of en or token loss.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= (state == IDLE) ? ((joined && en && below_max) ? START : IDLE)
                                  : (ap_ready ? IDLE : START);
  // Launch counter wraps naturally; protocol errors are sticky until reset.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      iter_count <= '0;
      err <= 1'b0;
    end else begin
      iter_count <= iter_count + ITER_W'(launch);
      err <= err | underflow | overflow;
    end
  kernel_bc_sched_credit_cnt #(.MAX(MAX_OUTSTANDING), .W(CNT_WIDTH)) u_credit (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc       (launch),
    .dec       (ap_done),
    .count     (outstanding),
    .below_max (below_max),
    .underflow (underflow),
    .overflow  (overflow)
  );
`ifdef KERNEL_BC_START_SCHED_PERF_EN
  logic stall;
  // A stall is a start waiting on the consumer or a partially filled join.
  always_comb stall = ap_start ? !ap_ready : (|src_empty_n && !(&src_empty_n));
  // Saturating stall cycle counter.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_kernel_bc_start_scheduler.sv
// tb_kernel_bc_start_scheduler: directed plus random scoreboard bench against a transaction-level model
module tb_kernel_bc_start_scheduler;
  localparam int NS = 2;
  localparam int MAXO = 4;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic ap_ready = 1'b0;
  logic ap_done = 1'b0;
  logic [NS-1:0] src_empty_n = '0;
  logic [NS-1:0] src_read;
  logic ap_start, busy, err;
  logic [CW-1:0] outstanding;
  logic [31:0] iter_count;
`ifdef KERNEL_BC_START_SCHED_PERF_EN
  logic [31:0] stall_cycles;
`endif

  kernel_bc_start_scheduler #(.NUM_SRC(NS), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .src_empty_n (src_empty_n),
    .src_read    (src_read),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .outstanding (outstanding),
    .iter_count  (iter_count),
    .busy        (busy),
    .err         (err)
`ifdef KERNEL_BC_START_SCHED_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] st, rd, out, it, bsy, er, stl;
  } snap_t;
  typedef struct {
    logic [31:0] it, out;
  } lch_t;
  snap_t sq[$];
  lch_t lq[$];

  int checks = 0;
  int failures = 0;

  bit m_start;
  int m_out;
  logic [31:0] m_iter, m_stall;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: record what this cycle should show, then advance the model across the edge.
  task automatic drive(input logic en_v, input logic [NS-1:0] e, input logic r, input logic d);
    bit lnch, part;
    @(posedge clk);
    #1;
    en = en_v;
    src_empty_n = e;
    ap_ready = r;
    ap_done = d;
    lnch = m_start && r;
    part = !m_start && e != '0 && e != '1;
    sq.push_back('{32'(m_start), 32'({NS{lnch}}), 32'(m_out), m_iter,
                   32'(m_start || m_out != 0), 32'(m_err), m_stall});
    if (lnch) lq.push_back('{m_iter, 32'(m_out)});
    if (((m_start && !r) || part) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (m_start) m_start = !r;
    else m_start = (e == '1) && en_v && m_out < MAXO;
    if (lnch) m_iter = m_iter + 1;
    if (lnch && !d) begin
      if (m_out == MAXO) m_err = 1'b1;
      else m_out++;
    end else if (d && !lnch) begin
      if (m_out == 0) m_err = 1'b1;
      else m_out--;
    end
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without waiting for an edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    chk("pre_rst_ap_start", ap_start, 32'(m_start));
    reset_n = 1'b0;
    #1;
    chk("rst_ap_start", ap_start, 0);
    chk("rst_src_read", src_read, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
`ifdef KERNEL_BC_START_SCHED_PERF_EN
    chk("rst_stall", stall_cycles, 0);
`endif
    sq.delete();
    lq.delete();
    m_start = 0;
    m_out = 0;
    m_iter = '0;
    m_err = 0;
    m_stall = '0;
    en = 0;
    src_empty_n = '0;
    ap_ready = 0;
    ap_done = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: launches are scored when the DUT pops, cycle status whenever an expectation is queued.
  initial begin
    snap_t s;
    lch_t l;
    forever begin
      @(negedge clk);
      if (!reset_n) continue;
      if (src_read != '0) begin
        if (lq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL launch_unexpected: src_read=%0b with no expected launch at %0t", src_read, $time);
        end else begin
          l = lq.pop_front();
          chk("launch_src_read", src_read, 32'({NS{1'b1}}));
          chk("launch_iter_before", iter_count, l.it);
          chk("launch_out_before", outstanding, l.out);
        end
      end
      if (sq.size() != 0) begin
        s = sq.pop_front();
        chk("ap_start", ap_start, s.st);
        chk("src_read", src_read, s.rd);
        chk("outstanding", outstanding, s.out);
        chk("iter_count", iter_count, s.it);
        chk("busy", busy, s.bsy);
        chk("err", err, s.er);
`ifdef KERNEL_BC_START_SCHED_PERF_EN
        chk("stall_cycles", stall_cycles, s.stl);
`endif
      end
    end
  end

  initial begin
    do_reset();
    // Partial join never launches; full join starts next cycle; ready pops both FIFOs.
    for (int i = 0; i < 10; i++) drive(1, 2'b01, 0, 0);
    drive(1, 2'b11, 0, 0);
    drive(1, 2'b11, 1, 0);
    drive(1, 2'b00, 0, 0);
    @(negedge clk);
    chk("s1_iter_one", iter_count, 1);
    chk("s1_out_one", outstanding, 1);
    // Back-to-back joins fill the credit limit, then a completion frees one launch.
    do_reset();
    for (int i = 0; i < 12; i++) drive(1, 2'b11, 1, 0);
    @(negedge clk);
    chk("s2_out_full", outstanding, MAXO);
    chk("s2_start_blocked", ap_start, 0);
    drive(1, 2'b11, 1, 1);
    for (int i = 0; i < 4; i++) drive(1, 2'b11, 1, 0);
    @(negedge clk);
    chk("s2_iter_five", iter_count, 5);
    // Start is held while en and tokens drop; pop returns to IDLE without relaunch.
    do_reset();
    drive(1, 2'b11, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 2'b00, 0, 0);
    drive(0, 2'b00, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 2'b00, 0, 0);
    // Launch coinciding with a completion leaves the count unchanged.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 2'b11, 1, 0);
    drive(1, 2'b11, 0, 0);
    drive(1, 2'b00, 1, 1);
    drive(1, 2'b00, 0, 0);
    @(negedge clk);
    chk("s4_out_two", outstanding, 2);
    chk("s4_iter_three", iter_count, 3);
    // Completion with nothing outstanding is a sticky error; then reset while in START.
    do_reset();
    drive(1, 2'b00, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 2'b00, 0, 0);
    @(negedge clk);
    chk("s5_err_sticky", err, 1);
    chk("s5_out_zero", outstanding, 0);
    drive(1, 2'b11, 0, 0);
    drive(1, 2'b11, 0, 0);
    do_reset();
`ifdef KERNEL_BC_START_SCHED_PERF_EN
    for (int i = 0; i < 3; i++) drive(1, 2'b01, 0, 0);
    drive(1, 2'b11, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 2'b11, 0, 0);
    drive(1, 2'b11, 1, 0);
    drive(0, 2'b00, 0, 0);
    @(negedge clk);
    chk("perf_stall_seven", stall_cycles, 7);
    do_reset();
`endif
    // Random traffic with legal completions only.
    for (int i = 0; i < 2000; i++) begin
      logic [NS-1:0] e;
      e = ($urandom_range(0, 1) == 1) ? '1 : NS'($urandom_range(0, 3));
      drive($urandom_range(0, 7) != 0, e, $urandom_range(0, 1) == 1,
            m_out > 0 && $urandom_range(0, 2) == 0);
    end
    drive(0, 2'b00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("launch_queue_drained", lq.size(), 0);
    chk("status_queue_drained", sq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kernel_bc_start_scheduler.md
Name: kernel_bc_start_scheduler

Overview:
- Join-and-launch controller for one consumer process in the kernel_bc dataflow region.
- Watches the read side of NUM_SRC start-token FIFOs (shift-register FIFOs with empty_n and read), one per upstream producer.
- When every FIFO holds a token, it drives the consumer's ap_start / ap_ready handshake, then pops exactly one token from each FIFO.
- Tracks launched-but-not-done iterations to bound pipelining depth and flags protocol errors.

Parameters:
- NUM_SRC, 2, number of upstream start FIFOs joined (1..8).
- MAX_OUTSTANDING, 4, maximum iterations started but not yet done (1..2^CNT_WIDTH-1).
- CNT_WIDTH, 3, width of the outstanding counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; gates new launches only.
- src_empty_n  in  NUM_SRC  per-FIFO "token available".
- src_read  out  NUM_SRC  per-FIFO pop strobe; the FIFO's read_ce is tied high.
- ap_start  out  1  consumer start request.
- ap_ready  in  1  consumer accepted start.
- ap_done  in  1  consumer finished one iteration (1-cycle pulse).
- outstanding  out  CNT_WIDTH  iterations in flight.
- iter_count  out  32  total launches since reset; wraps modulo 2^32.
- busy  out  1  high when state is START or outstanding is nonzero.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync-safe deassert is handled externally):
  - state=IDLE; ap_start=0, src_read=0, outstanding=0, iter_count=0, busy=0, err=0.
  - Reset asserted mid-START drops ap_start immediately. No pop occurs.
- FSM has two states: IDLE and START. ap_start is a registered Moore output, 1 exactly in START.
- IDLE -> START at an edge when all of the following hold: all src_empty_n bits are 1, en=1, and outstanding < MAX_OUTSTANDING.
- START -> IDLE at the edge where ap_ready=1.
- START holds while ap_ready=0. ap_start is never withdrawn once raised, even if en falls or a src_empty_n bit falls.
- src_read = {NUM_SRC{state==START && ap_ready}}; combinational, 1-cycle pulse, all bits together.
- The FIFO empty_n flags settle at the same edge as the pop, so the IDLE evaluation in the next cycle sees updated flags.
- Throughput is at most one launch per 2 cycles. Launch latency is 1 cycle from the join condition to ap_start.
- Counter updates on each edge:
  - +1 on a launch (START and ap_ready), -1 on ap_done. Both in the same cycle leaves it unchanged.
  - ap_done while outstanding==0 (and no simultaneous launch): counter stays 0 and err sets.
  - A launch when outstanding==MAX_OUTSTANDING is unreachable by construction; it sets err if it occurs.
- iter_count +1 on each launch; 0xFFFFFFFF wraps to 0.
- err clears only on reset.

Optional Feature:
- KERNEL_BC_START_SCHED_PERF_EN defined:
  - Adds output stall_cycles [31:0], reset to 0, saturating at 0xFFFFFFFF.
  - Increments each cycle that is either (a) START with ap_ready=0, or (b) IDLE with src_empty_n neither all-0 nor all-1 (partial join).
- Undefined: no port and no logic; behaviour otherwise identical.

Decomposition:
- Package kernel_bc_sched_pkg holds:
  - state enum (IDLE=1'b0, START=1'b1);
  - ITER_W=32 and PERF_W=32 constants;
  - the function computing the all-ones join of a NUM_SRC vector.
- One sub-module, kernel_bc_sched_credit_cnt, implements the up/down outstanding counter with limit compare and underflow/overflow error outputs.
- The FSM stays in the top.

Test Plan:
- NUM_SRC=2. Only src_empty_n=2'b01 for 10 cycles -> ap_start stays 0 and src_read=0. Set 2'b11 -> ap_start=1 the next cycle. ap_ready=1 for 1 cycle -> src_read=2'b11 that cycle, outstanding=1, iter_count=1.
- Hold src_empty_n=2'b11, ap_ready=1 permanently, no ap_done -> launches on cycles 1,3,5,7. outstanding reaches 4, then ap_start stays 0. One ap_done pulse -> outstanding=3 and one more launch follows.
- In START, drop en and src_empty_n to 0 with ap_ready=0 for 5 cycles -> ap_start held at 1 throughout. ap_ready then pops and returns to IDLE; no relaunch occurs.
- Launch and ap_done in the same cycle with outstanding=2 -> outstanding stays 2 and iter_count increments.
- ap_done with outstanding=0 -> err=1, outstanding=0, and err stays 1 until reset. Assert reset_n=0 mid-START -> ap_start=0 with no clock edge required, and all counters clear.
- With KERNEL_BC_START_SCHED_PERF_EN: 3 partial-join cycles plus 4 START cycles waiting on ap_ready -> stall_cycles=7.
